// File: rtl/inst_loader_pkg.sv
// Shared types for the instruction boot loader: sync byte, bus widths, FSM.
// Build with LOADER_CHECKSUM_EN to append and verify an XOR checksum byte.
package inst_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Where a frame goes once its last data word (or an empty count) is seen
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FRAME_END = S_CSUM;
`else
  localparam state_t S_FRAME_END = S_DONE;
`endif

  function automatic logic timed_state(state_t s);
    logic w_t;
    w_t = (s == S_LEN_HI) ||
          (s == S_LEN_LO) ||
          (s == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    w_t = w_t || (s == S_CSUM);
`endif
    return w_t;
  endfunction

endpackage

// File: rtl/inst_loader_timeout.sv
// Mid-frame idle counter for the boot loader.
// Flags expiry on the cycle the TIMEOUT_CYCLES-th idle edge would land.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit = (r_cnt == LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (!w_hit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // An accepted byte in the same cycle always beats the timeout
  assign o_expired = i_en && !i_clr && w_hit;

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream boot loader writing big-endian words into the inst ROM.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [INST_W-1:0] rom_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  state_t r_state;
  state_t w_next;

  logic              r_live;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_remain;
  logic [1:0]        r_idx;
  logic [23:0]       r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [INST_W-1:0] r_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_acc;
  logic        w_expired;
  logic        w_timed;
  logic        w_last_byte;
  logic        w_last_word;
  logic [15:0] w_len;

  assign w_acc       = in_valid && in_ready;
  assign w_len       = {r_len_hi, in_data};
  assign w_last_byte = (r_idx == 2'd3);
  assign w_last_word = (r_remain == 16'd1);
  assign w_timed     = timed_state(r_state);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_clr    (w_acc),
    .i_en     (w_timed),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && in_data == LOADER_SYNC) begin
          w_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_acc) begin
          w_next = S_LEN_LO;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
      S_LEN_LO: begin
        if (w_acc) begin
          w_next = (w_len == 16'd0) ? S_FRAME_END : S_DATA;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
      S_DATA: begin
        if (w_acc) begin
          if (w_last_byte && w_last_word) begin
            w_next = S_FRAME_END;
          end
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_acc) begin
          w_next = (in_data == r_csum) ? S_DONE : S_ERR;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
`endif
      S_DONE: w_next = S_DONE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    cpu_run  = 1'b0;
    error    = 1'b0;
    unique case (r_state)
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        in_ready = r_live;
      end
    endcase
  end

  // r_live keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live   <= 1'b0;
      r_len_hi <= 8'h00;
      r_remain <= 16'h0000;
      r_idx    <= 2'd0;
      r_shift  <= 24'h0;
      r_addr   <= BASE_ADDR;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum   <= 8'h00;
`endif
    end else begin
      r_live <= 1'b1;
      r_we   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_addr <= BASE_ADDR;
          r_idx  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
          r_csum <= 8'h00;
`endif
        end
        S_LEN_HI: begin
          if (w_acc) begin
            r_len_hi <= in_data;
          end
        end
        S_LEN_LO: begin
          if (w_acc) begin
            r_remain <= w_len;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_shift <= {r_shift[15:0], in_data};
            r_idx   <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ in_data;
`endif
            if (w_last_byte) begin
              r_we     <= 1'b1;
              r_waddr  <= r_addr;
              r_wdata  <= {r_shift, in_data};
              r_addr   <= r_addr + 32'd4;
              r_remain <= r_remain - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_we    = r_we;
  assign rom_waddr = r_waddr;
  assign rom_wdata = r_wdata;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: byte-level reference model plus
// directed frames and randomized frames with gaps, truncation and resets.
module tb_inst_loader;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef enum int {P_IDLE, P_LHI, P_LLO, P_DATA, P_CSUM, P_DONE, P_ERR} ph_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;

  inst_loader #(
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rom_we   (rom_we),
    .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] w_log[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-level frame interpreter
  ph_t         m_phase = P_IDLE;
  bit          m_on = 1'b0;
  bit          m_live = 1'b0;
  int          m_words, m_nb, m_idle;
  logic [15:0] m_len;
  logic [31:0] m_addr, m_word;
  logic [7:0]  m_csum;
  logic        e_ready = 1'b0;
  logic        e_we = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_waddr = '0;
  logic [31:0] e_wdata = '0;

  task automatic frame_end();
    m_phase = CSUM_EN ? P_CSUM : P_DONE;
  endtask

  task automatic feed(input logic [7:0] b);
    case (m_phase)
      P_IDLE: if (b == 8'hA5) begin
        m_phase = P_LHI; m_addr = BASE; m_csum = 8'h00; m_nb = 0;
      end
      P_LHI: begin m_len[15:8] = b; m_phase = P_LLO; end
      P_LLO: begin
        m_len[7:0] = b;
        if (m_len == 16'd0) frame_end();
        else begin m_words = int'(m_len); m_phase = P_DATA; end
      end
      P_DATA: begin
        m_word = {m_word[23:0], b};
        m_csum = m_csum ^ b;
        m_nb++;
        if (m_nb == 4) begin
          e_we = 1'b1; e_waddr = m_addr; e_wdata = m_word;
          m_addr = m_addr + 32'd4; m_nb = 0; m_words--;
          if (m_words == 0) frame_end();
        end
      end
      P_CSUM: m_phase = (b == m_csum) ? P_DONE : P_ERR;
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_on = 1'b1; m_live = 1'b0; m_phase = P_IDLE; m_idle = 0;
      e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    end else if (m_on) begin
      e_we = 1'b0;
      if (in_valid && e_ready) begin
        m_idle = 0;
        feed(in_data);
      end else if (m_phase inside {P_LHI, P_LLO, P_DATA, P_CSUM}) begin
        m_idle++;
        if (m_idle >= TO) m_phase = P_ERR;
      end
      m_live = 1'b1;
    end
    e_ready = m_live && m_phase != P_DONE && m_phase != P_ERR;
    e_done  = (m_phase == P_DONE);
    e_err   = (m_phase == P_ERR);
  end

  // Per-cycle compare against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      n_chk++;
      if ({in_ready, rom_we, done, cpu_run, error} !==
          {e_ready, e_we, e_done, e_done, e_err}) begin
        n_err++;
        $display("FAIL cycle_ctl @%0t: got rdy/we/done/run/err=%b expected %b",
                 $time, {in_ready, rom_we, done, cpu_run, error},
                 {e_ready, e_we, e_done, e_done, e_err});
      end
      if (e_we) begin
        n_chk++;
        if ({rom_waddr, rom_wdata} !== {e_waddr, e_wdata}) begin
          n_err++;
          $display("FAIL cycle_wr @%0t: got %h@%h expected %h@%h", $time,
                   rom_wdata, rom_waddr, e_wdata, e_waddr);
        end
      end
    end
    if (rom_we === 1'b1) w_log.push_back({rom_waddr, rom_wdata});
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic send_q(input bq_t f);
    foreach (f[i]) send(f[i]);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    w_log.delete();
  endtask

  task automatic rand_frame();
    bq_t f;
    int cnt, rst_at, r, g;
    logic [7:0] b, cs;
    f = {};
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      f.push_back(b);
    end
    cnt = $urandom_range(0, 4);
    f.push_back(8'hA5);
    f.push_back(8'(cnt >> 8));
    f.push_back(8'(cnt));
    cs = 8'h00;
    repeat (cnt * 4) begin
      b = 8'($urandom);
      cs = cs ^ b;
      f.push_back(b);
    end
    if ($urandom_range(0, 5) == 0) cs = cs ^ 8'($urandom_range(1, 255));
    f.push_back(cs);
    if ($urandom_range(0, 7) == 0) f = f[0:$urandom_range(0, f.size() - 2)];
    rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, f.size() - 1) : -1;
    do_reset();
    foreach (f[i]) begin
      if (i == rst_at) do_reset();
      send(f[i]);
      r = $urandom_range(0, 19);
      g = (r == 0) ? TO : (r == 1) ? TO - 1 : (r < 8) ? $urandom_range(1, 2) : 0;
      idle(g);
    end
    idle(TO + 3);
  endtask

  initial begin
    bq_t f;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", rom_we, 0);
    chk("rst_wbus", {rom_waddr, rom_wdata}, 0);
    chk("rst_flags", {done, cpu_run, error}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // XOR of the eight data bytes is 0x66
    w_log.delete();
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
          8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CSUM_EN) f.push_back(8'h66);
    send_q(f);
    chk("t1_nwr", w_log.size(), 2);
    chk("t1_w0", w_log[0], {32'h0, 32'h11223344});
    chk("t1_w1", w_log[1], {32'h4, 32'hDEADBEEF});
    chk("t1_flags", {done, cpu_run, in_ready, error}, 4'b1100);

    do_reset();
    f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CSUM_EN) f.push_back(8'h04);
    send_q(f);
    chk("t2_nwr", w_log.size(), 1);
    chk("t2_w0", w_log[0], {32'h0, 32'h01020304});
    chk("t2_done", done, 1);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
          8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_q(f);
    chk("t3_nwr", w_log.size(), 2);
    chk("t3_error", error, CSUM_EN);
    chk("t3_run", cpu_run, !CSUM_EN);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h01, 8'h11};
    foreach (f[i]) send(f[i]);
    send(8'h22);
    idle(1);
    repeat (15) @(negedge clk);
    chk("t4_err_before", {error, in_ready}, 2'b01);
    @(negedge clk);
    chk("t4_err_at", {error, cpu_run, in_ready}, 3'b100);
    chk("t4_nwr", w_log.size(), 0);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    foreach (f[i]) send(f[i]);
    do_reset();
    f = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CSUM_EN) f.push_back(8'hCC);
    send_q(f);
    chk("t5_nwr", w_log.size(), 1);
    chk("t5_w0", w_log[0], {BASE, 32'h55667788});
    chk("t5_done", done, 1);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h00};
    if (CSUM_EN) f.push_back(8'h00);
    send_q(f);
    chk("t6_nwr", w_log.size(), 0);
    chk("t6_done", {done, cpu_run}, 2'b11);

    for (int k = 0; k < 60; k++) rand_frame();

    idle(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
